seg7_p2s_tx: RTL



---
 rtl/seg7_pkg.sv | 19 +
 rtl/hex_to_seg7.sv | 21 ++
 rtl/seg7_p2s_tx.sv | 110 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment serial transmitter: segment table,
// FSM state encoding and frame width.
package seg7_pkg;

    localparam int FRAME_W = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Active-low {dp,g,f,e,d,c,b,a} codes with dp off; entry i is hex digit i.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// One hex digit to an active-low segment byte; blanking overrides the point.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
        if (dp) begin
            seg[7] = 1'b0;
        end
        if (blank) begin
            seg = 8'hFF;
        end
    end

endmodule

// File: rtl/seg7_p2s_tx.sv
// Snapshots eight digits into a 64-bit segment frame and shifts it MSB-first
// onto the display chain, with a free-running blink timer.
module seg7_p2s_tx
    import seg7_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int BLINK_BIT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  point,
    input  logic [7:0]  LE,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_pen,
    output logic        seg_clrn,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0]         DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [BLINK_BIT:0] BLINK_ONE = 1;

    logic [BLINK_BIT:0]   blink_cnt;
    logic                 blink_ph;
    logic [FRAME_W-1:0]   frame;
    logic [FRAME_W-1:0]   shreg;
    logic [7:0]           div_cnt;
    logic [5:0]           bit_cnt;
    state_t               state;

    assign blink_ph = blink_cnt[BLINK_BIT];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            hex_to_seg7 u_hex (
                .nibble (Disp_num[4*gi+3:4*gi]),
                .dp     (point[gi]),
                .blank  (LE[gi] & blink_ph),
                .seg    (frame[8*gi+7:8*gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            state     <= ST_IDLE;
            shreg     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            seg_clk   <= 1'b0;
            seg_sout  <= 1'b0;
            seg_pen   <= 1'b0;
            seg_clrn  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_ONE;
            seg_clrn  <= 1'b1;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SHIFT;
                        shreg    <= frame;
                        seg_sout <= frame[FRAME_W-1];
                        bit_cnt  <= 6'd63;
                        div_cnt  <= '0;
                        seg_clk  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!seg_clk) begin
                            seg_clk <= 1'b1;
                        end else begin
                            // Falling edge: the only point where data may move.
                            seg_clk <= 1'b0;
                            if (bit_cnt == 6'd0) begin
                                state   <= ST_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                seg_pen <= 1'b1;
                            end else begin
                                bit_cnt  <= bit_cnt - 6'd1;
                                shreg    <= {shreg[FRAME_W-2:0], 1'b0};
                                seg_sout <= shreg[FRAME_W-2];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
